// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the PIPE receive packer: the RxStatus codes, the
// K28.5 (COM) and K30.7 (EDB) symbol values, the lock FSM state enum and a
// helper that picks the RxStatus code from the accumulated error flags.
// No ports (package).
package pipe_pkg;

  localparam logic [2:0] RXSTAT_OK      = 3'b000;
  localparam logic [2:0] RXSTAT_DECERR  = 3'b100;
  localparam logic [2:0] RXSTAT_DISPERR = 3'b111;

  localparam logic [7:0] K28_5 = 8'hBC;  // COM, alignment symbol
  localparam logic [7:0] K30_7 = 8'hFE;  // EDB, substitute for bad symbols

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } rxLockState_t;

  // A decode error anywhere in the word outranks a disparity error.
  function automatic logic [2:0] rxStatusCode(input logic anyDecErr,
                                              input logic anyDispErr);
    if (anyDecErr) begin
      return RXSTAT_DECERR;
    end
    if (anyDispErr) begin
      return RXSTAT_DISPERR;
    end
    return RXSTAT_OK;
  endfunction

endpackage

// File: rtl/pipe_rx_sym_check.sv
// pipe_rx_sym_check
// Purely combinational classification of one decoded symbol: substitutes
// EDB (K=1) for symbols carrying a decode error, passes the error flags on,
// and (only when PIPE_RX_COM_ALIGN_EN is defined) flags a clean COM symbol.
// Ports:
//   symData    in  8  decoded symbol
//   symK       in  1  symbol is a K-code
//   symDecErr  in  1  code violation on this symbol
//   symDispErr in  1  disparity error on this symbol
//   isCom      out 1  clean COM symbol (PIPE_RX_COM_ALIGN_EN builds only)
//   storeByte  out 8  byte to store in the word
//   storeK     out 1  K flag to store with it
//   decFlag    out 1  decode error for status accumulation
//   dispFlag   out 1  disparity error for status accumulation
module pipe_rx_sym_check #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter logic [7:0] EDB_SYMBOL = 8'hFE
) (
  input  logic [7:0] symData,
  input  logic       symK,
  input  logic       symDecErr,
  input  logic       symDispErr,
`ifdef PIPE_RX_COM_ALIGN_EN
  output logic       isCom,
`endif
  output logic [7:0] storeByte,
  output logic       storeK,
  output logic       decFlag,
  output logic       dispFlag
);

`ifdef PIPE_RX_COM_ALIGN_EN
  // A COM damaged by either error must not be trusted for alignment.
  assign isCom = symK && (symData == COM_SYMBOL) && !symDecErr && !symDispErr;
`else
  logic unusedComSymbol;
  assign unusedComSymbol = ^COM_SYMBOL;
`endif

  assign storeByte = symDecErr ? EDB_SYMBOL : symData;
  assign storeK    = symDecErr | symK;
  assign decFlag   = symDecErr;
  assign dispFlag  = symDispErr;

endmodule

// File: rtl/pipe_rx_packer.sv
// pipe_rx_packer
// Packs decoded 8b/10b symbols into DATA_WIDTH-bit PIPE receive words with
// per-byte K flags and a per-word RxStatus, and tracks symbol lock.
// Optional feature macro PIPE_RX_COM_ALIGN_EN: lock only on a clean COM and
// realign the word boundary on every COM; when undefined the first valid
// symbol locks and packing is free-running.
// Ports:
//   PCLK         in  1             clock, rising edge
//   Reset        in  1             asynchronous active-high reset
//   SymData      in  8             decoded symbol
//   SymK         in  1             symbol is a K-code
//   SymValid     in  1             symbol qualifier
//   SymDecErr    in  1             code violation flag
//   SymDispErr   in  1             disparity error flag
//   RxElecIdle   in  1             electrical idle, forces unlock
//   RxData       out DATA_WIDTH    packed word, byte 0 earliest
//   RxDataK      out DATA_WIDTH/8  per-byte K flags
//   RxWordStrobe out 1             one-cycle pulse per new word
//   RxValid      out 1             symbol lock
//   RxStatus     out 3             status of the strobed word
module pipe_rx_packer
  import pipe_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] COM_SYMBOL = K28_5,
  parameter logic [7:0] EDB_SYMBOL = K30_7
) (
  input  logic                    PCLK,
  input  logic                    Reset,
  input  logic [7:0]              SymData,
  input  logic                    SymK,
  input  logic                    SymValid,
  input  logic                    SymDecErr,
  input  logic                    SymDispErr,
  input  logic                    RxElecIdle,
  output logic [DATA_WIDTH-1:0]   RxData,
  output logic [DATA_WIDTH/8-1:0] RxDataK,
  output logic                    RxWordStrobe,
  output logic                    RxValid,
  output logic [2:0]              RxStatus
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

  rxLockState_t          stateReg, stateNext;
  logic [IDXW-1:0]       idxReg, idxNext;
  logic [DATA_WIDTH-1:0] dataAccReg, dataAccNext;
  logic [NB-1:0]         kAccReg, kAccNext;
  logic                  decAccReg, decAccNext;
  logic                  dispAccReg, dispAccNext;
  logic [DATA_WIDTH-1:0] rxDataReg, rxDataNext;
  logic [NB-1:0]         rxDataKReg, rxDataKNext;
  logic [2:0]            rxStatusReg, rxStatusNext;
  logic                  strobeReg, strobeNext;

  logic                  accept;
  logic [IDXW-1:0]       slot;
  logic [NB-1:0]         byteSel;

  logic [7:0]            storeByte;
  logic                  storeK;
  logic                  decFlag;
  logic                  dispFlag;
`ifdef PIPE_RX_COM_ALIGN_EN
  logic                  isCom;
  logic                  realign;
`endif

  pipe_rx_sym_check #(
    .COM_SYMBOL (COM_SYMBOL),
    .EDB_SYMBOL (EDB_SYMBOL)
  ) symCheck (
    .symData    (SymData),
    .symK       (SymK),
    .symDecErr  (SymDecErr),
    .symDispErr (SymDispErr),
`ifdef PIPE_RX_COM_ALIGN_EN
    .isCom      (isCom),
`endif
    .storeByte  (storeByte),
    .storeK     (storeK),
    .decFlag    (decFlag),
    .dispFlag   (dispFlag)
  );

  // One-hot lane select for the byte slot being written this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : gByteSel
      assign byteSel[gi] = (slot == IDXW'(gi));
    end
  endgenerate

  always_ff @(posedge PCLK or posedge Reset) begin
    if (Reset) begin
      stateReg    <= UNLOCKED;
      idxReg      <= '0;
      dataAccReg  <= '0;
      kAccReg     <= '0;
      decAccReg   <= 1'b0;
      dispAccReg  <= 1'b0;
      rxDataReg   <= '0;
      rxDataKReg  <= '0;
      rxStatusReg <= RXSTAT_OK;
      strobeReg   <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      idxReg      <= idxNext;
      dataAccReg  <= dataAccNext;
      kAccReg     <= kAccNext;
      decAccReg   <= decAccNext;
      dispAccReg  <= dispAccNext;
      rxDataReg   <= rxDataNext;
      rxDataKReg  <= rxDataKNext;
      rxStatusReg <= rxStatusNext;
      strobeReg   <= strobeNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    idxNext      = idxReg;
    dataAccNext  = dataAccReg;
    kAccNext     = kAccReg;
    decAccNext   = decAccReg;
    dispAccNext  = dispAccReg;
    rxDataNext   = rxDataReg;
    rxDataKNext  = rxDataKReg;
    rxStatusNext = rxStatusReg;
    strobeNext   = 1'b0;
    accept       = 1'b0;
    slot         = idxReg;
`ifdef PIPE_RX_COM_ALIGN_EN
    realign      = 1'b0;
`endif

    if (RxElecIdle) begin
      // Idle outranks everything, including a word-completing symbol.
      stateNext   = UNLOCKED;
      idxNext     = '0;
      decAccNext  = 1'b0;
      dispAccNext = 1'b0;
    end else if (SymValid) begin
      unique case (stateReg)
        UNLOCKED: begin
`ifdef PIPE_RX_COM_ALIGN_EN
          if (isCom) begin
            stateNext = LOCKED;
            accept    = 1'b1;
            slot      = '0;
          end
`else
          stateNext = LOCKED;
          accept    = 1'b1;
          slot      = '0;
`endif
        end
        LOCKED: begin
          accept = 1'b1;
`ifdef PIPE_RX_COM_ALIGN_EN
          // COM restarts the word at byte 0; any partial word is dropped.
          if (isCom) begin
            realign = 1'b1;
            slot    = '0;
          end
`endif
        end
        default: ;
      endcase
    end

    if (accept) begin
`ifdef PIPE_RX_COM_ALIGN_EN
      if (realign) begin
        decAccNext  = 1'b0;
        dispAccNext = 1'b0;
      end
`endif
      for (int b = 0; b < NB; b++) begin
        if (byteSel[b]) begin
          dataAccNext[b*8 +: 8] = storeByte;
          kAccNext[b]           = storeK;
        end
      end
      decAccNext  = decAccNext | decFlag;
      dispAccNext = dispAccNext | dispFlag;

      if (slot == LAST_IDX) begin
        strobeNext   = 1'b1;
        rxDataNext   = dataAccNext;
        rxDataKNext  = kAccNext;
        rxStatusNext = rxStatusCode(decAccNext, dispAccNext);
        idxNext      = '0;
        decAccNext   = 1'b0;
        dispAccNext  = 1'b0;
      end else begin
        idxNext = slot + IDXW'(1);
      end
    end
  end

  assign RxData       = rxDataReg;
  assign RxDataK      = rxDataKReg;
  assign RxStatus     = rxStatusReg;
  assign RxWordStrobe = strobeReg;
  assign RxValid      = (stateReg == LOCKED);

endmodule

// File: tb/tb_pipe_rx_packer.sv
// tb_pipe_rx_packer
// Bench for pipe_rx_packer at DATA_WIDTH=32. Directed sequences for the
// boundary cases, then randomized symbol traffic, all compared each cycle
// against a queue-based reference model. Works with PIPE_RX_COM_ALIGN_EN
// either defined or undefined.
`timescale 1ns/1ps
module tb_pipe_rx_packer;

  localparam int         DW  = 32;
  localparam int         NB  = DW / 8;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] EDB = 8'hFE;

  logic          PCLK = 1'b0;
  logic          Reset;
  logic [7:0]    SymData;
  logic          SymK, SymValid, SymDecErr, SymDispErr, RxElecIdle;
  logic [DW-1:0] RxData;
  logic [NB-1:0] RxDataK;
  logic          RxWordStrobe, RxValid;
  logic [2:0]    RxStatus;

  pipe_rx_packer #(
    .DATA_WIDTH (DW),
    .COM_SYMBOL (COM),
    .EDB_SYMBOL (EDB)
  ) dut (
    .PCLK         (PCLK),
    .Reset        (Reset),
    .SymData      (SymData),
    .SymK         (SymK),
    .SymValid     (SymValid),
    .SymDecErr    (SymDecErr),
    .SymDispErr   (SymDispErr),
    .RxElecIdle   (RxElecIdle),
    .RxData       (RxData),
    .RxDataK      (RxDataK),
    .RxWordStrobe (RxWordStrobe),
    .RxValid      (RxValid),
    .RxStatus     (RxStatus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] b;
    logic       k;
    logic       dec;
    logic       disp;
  } symT;

  // Reference model state: symbols of the word in progress, lock flag and
  // the held output word.
  symT           partial[$];
  bit            locked;
  logic [DW-1:0] expData;
  logic [NB-1:0] expK;
  logic [2:0]    expStatus;
  logic          expStrobe;

  int checkCount = 0;
  int errorCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    locked = 1'b0;
    partial.delete();
    expData   = '0;
    expK      = '0;
    expStatus = 3'b000;
    expStrobe = 1'b0;
  endtask

  task automatic emitWord();
    bit anyDec, anyDisp;
    anyDec  = 1'b0;
    anyDisp = 1'b0;
    for (int i = 0; i < NB; i++) begin
      expData[8*i +: 8] = partial[i].b;
      expK[i]           = partial[i].k;
      anyDec  |= partial[i].dec;
      anyDisp |= partial[i].disp;
    end
    expStatus = anyDec ? 3'b100 : (anyDisp ? 3'b111 : 3'b000);
    expStrobe = 1'b1;
    partial.delete();
  endtask

  // Effect of one rising edge with the current inputs (Reset low).
  task automatic modelEdge();
    symT s;
`ifdef PIPE_RX_COM_ALIGN_EN
    bit isCom;
`endif
    expStrobe = 1'b0;
    if (RxElecIdle) begin
      locked = 1'b0;
      partial.delete();
    end else if (SymValid) begin
      s.b    = SymDecErr ? EDB : SymData;
      s.k    = SymDecErr | SymK;
      s.dec  = SymDecErr;
      s.disp = SymDispErr;
`ifdef PIPE_RX_COM_ALIGN_EN
      isCom = SymK && (SymData == COM) && !SymDecErr && !SymDispErr;
      if (isCom) begin
        locked = 1'b1;
        partial.delete();
        partial.push_back(s);
      end else if (locked) begin
        partial.push_back(s);
      end
`else
      locked = 1'b1;
      partial.push_back(s);
`endif
      if (partial.size() == NB) emitWord();
    end
  endtask

  task automatic compareAll();
    checkVal("strobe",   32'(RxWordStrobe), 32'(expStrobe));
    checkVal("rxvalid",  32'(RxValid),      32'(locked));
    checkVal("rxdata",   32'(RxData),       32'(expData));
    checkVal("rxdatak",  32'(RxDataK),      32'(expK));
    checkVal("rxstatus", 32'(RxStatus),     32'(expStatus));
    if (RxWordStrobe)
      $display("word t=%0t data=%h k=%b status=%b", $time, RxData, RxDataK, RxStatus);
  endtask

  // Called at posedge+1: drive, take one edge, sample 1ns later.
  task automatic step(input logic v, input logic [7:0] d, input logic k,
                      input logic de, input logic di, input logic idle);
    SymValid   = v;
    SymData    = d;
    SymK       = k;
    SymDecErr  = de;
    SymDispErr = di;
    RxElecIdle = idle;
    @(posedge PCLK);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic sendByte(input logic [7:0] d, input logic k);
    step(1'b1, d, k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic gap();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset is asynchronous: outputs must clear before the next clock edge.
  task automatic resetPulse();
    SymValid   = 1'b0;
    RxElecIdle = 1'b0;
    Reset      = 1'b1;
    #1;
    modelReset();
    compareAll();
    @(posedge PCLK);
    #1;
    compareAll();
    Reset = 1'b0;
  endtask

  initial begin
    Reset      = 1'b1;
    SymValid   = 1'b0;
    SymData    = 8'h00;
    SymK       = 1'b0;
    SymDecErr  = 1'b0;
    SymDispErr = 1'b0;
    RxElecIdle = 1'b0;
    modelReset();
    repeat (2) @(posedge PCLK);
    #1;
    compareAll();
    checkVal("reset_rxdata", 32'(RxData), 32'h0);
    checkVal("reset_rxvalid", 32'(RxValid), 32'h0);
    Reset = 1'b0;

`ifdef PIPE_RX_COM_ALIGN_EN
    sendByte(8'h77, 1'b0);                      // dropped while unlocked
    checkVal("unlocked_drop_valid", 32'(RxValid), 32'h0);
    sendByte(COM, 1'b1);
    checkVal("lock_on_com", 32'(RxValid), 32'h1);
    sendByte(8'h4A, 1'b0); sendByte(8'h11, 1'b0); sendByte(8'h22, 1'b0);
    checkVal("first_word", 32'(RxData), 32'h22114ABC);
    checkVal("first_word_k", 32'(RxDataK), 32'h1);
    sendByte(8'h01, 1'b0); sendByte(8'h02, 1'b0); sendByte(COM, 1'b1);
    checkVal("realign_no_strobe", 32'(RxWordStrobe), 32'h0);
    sendByte(8'h03, 1'b0); sendByte(8'h04, 1'b0); sendByte(8'h05, 1'b0);
    checkVal("realign_strobe", 32'(RxWordStrobe), 32'h1);
    checkVal("realign_word", 32'(RxData), 32'h050403BC);
    checkVal("realign_k", 32'(RxDataK), 32'h1);
    sendByte(COM, 1'b1);
    step(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    sendByte(8'h20, 1'b0);
    checkVal("decerr_word", 32'(RxData), 32'h20FE10BC);
    checkVal("decerr_k", 32'(RxDataK), 32'h5);
    checkVal("decerr_status", 32'(RxStatus), 32'h4);
    sendByte(COM, 1'b1);
    step(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    sendByte(8'h11, 1'b0); sendByte(8'h12, 1'b0);
    checkVal("disperr_status", 32'(RxStatus), 32'h7);
    sendByte(COM, 1'b1); sendByte(8'h55, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("idle_unlock", 32'(RxValid), 32'h0);
    sendByte(8'h77, 1'b0);
    sendByte(COM, 1'b1); sendByte(8'h01, 1'b0); sendByte(8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);  // idle beats completion
    checkVal("idle_wins_strobe", 32'(RxWordStrobe), 32'h0);
    sendByte(COM, 1'b1); sendByte(8'h01, 1'b0); sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    checkVal("relock_word", 32'(RxData), 32'h030201BC);
    sendByte(COM, 1'b1); sendByte(8'h01, 1'b0);
    resetPulse();
    checkVal("midword_reset_data", 32'(RxData), 32'h0);
    checkVal("midword_reset_valid", 32'(RxValid), 32'h0);
    sendByte(8'h09, 1'b0);
    sendByte(COM, 1'b1); sendByte(8'hA1, 1'b0); sendByte(8'hA2, 1'b0);
    sendByte(8'hA3, 1'b0);
    checkVal("after_reset_word", 32'(RxData), 32'hA3A2A1BC);
`else
    sendByte(8'hAA, 1'b0);
    checkVal("lock_first_valid", 32'(RxValid), 32'h1);
    gap(); gap(); gap();
    sendByte(8'hBB, 1'b0); sendByte(8'hCC, 1'b0);
    checkVal("gap_no_strobe", 32'(RxWordStrobe), 32'h0);
    sendByte(8'hDD, 1'b0);
    checkVal("gap_strobe", 32'(RxWordStrobe), 32'h1);
    checkVal("gap_word", 32'(RxData), 32'hDDCCBBAA);
    sendByte(COM, 1'b1); sendByte(8'h01, 1'b0); sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    checkVal("com_as_data", 32'(RxData), 32'h030201BC);
    checkVal("com_as_data_k", 32'(RxDataK), 32'h1);
    step(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    sendByte(8'h20, 1'b0); sendByte(8'h30, 1'b0);
    checkVal("decerr_word", 32'(RxData), 32'h3020FE10);
    checkVal("decerr_k", 32'(RxDataK), 32'h2);
    checkVal("decerr_status", 32'(RxStatus), 32'h4);
    sendByte(8'h01, 1'b0); sendByte(8'h02, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("idle_unlock", 32'(RxValid), 32'h0);
    sendByte(8'h0A, 1'b0); sendByte(8'h0B, 1'b0); sendByte(8'h0C, 1'b0);
    sendByte(8'h0D, 1'b0);
    checkVal("relock_word", 32'(RxData), 32'h0D0C0B0A);
    sendByte(8'h01, 1'b0); sendByte(8'h02, 1'b0);
    resetPulse();
    checkVal("midword_reset_data", 32'(RxData), 32'h0);
    checkVal("midword_reset_valid", 32'(RxValid), 32'h0);
    sendByte(8'hA0, 1'b0); sendByte(8'hA1, 1'b0); sendByte(8'hA2, 1'b0);
    sendByte(8'hA3, 1'b0);
    checkVal("after_reset_word", 32'(RxData), 32'hA3A2A1A0);
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      logic       v, k, de, di, idle, com;
      logic [7:0] d;
      if ($urandom_range(0, 399) == 0) begin
        resetPulse();
      end else begin
        v    = ($urandom_range(0, 9) < 7);
        com  = ($urandom_range(0, 9) == 0);
        d    = com ? COM : 8'($urandom);
        k    = com ? 1'b1 : ($urandom_range(0, 9) == 0);
        de   = ($urandom_range(0, 19) == 0);
        di   = ($urandom_range(0, 19) == 0);
        idle = ($urandom_range(0, 59) == 0);
        step(v, d, k, de, di, idle);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
